// File: rtl/condunit.sv
// condunit: conditional-execution and ALU-decode stage for the multicycle ARM core.
// Gates the control-unit write strobes with the instruction's condition field,
// selects the ALU function and holds the architectural NZCV flags.
// Optional build macro CONDUNIT_STATS_EN adds executed/squashed decode counters
// (ExecCnt, SquashCnt).
module condunit (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRWrite,
  input  logic [3:0]  Cond,
  input  logic [5:0]  Funct,
  input  logic        ALUOp,
  input  logic        NextPC,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        Branch,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic        CondEx
`ifdef CONDUNIT_STATS_EN
  ,
  output logic [15:0] ExecCnt,
  output logic [15:0] SquashCnt
`endif
);

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  logic    decode_q;
  logic    cond_q;
  logic    cond_true;
  logic    n, z, c, v;
  logic    cmd_ok;
  logic    is_cmp;
  logic    flag_w_nz;
  logic    flag_w_cv;
  alu_op_e alu_op;

  assign {n, z, c, v} = Flags;

  // Condition-field evaluation against the registered (pre-update) flags.
  always_comb begin
    cond_true = 1'b0;
    unique case (Cond)
      4'b0000: cond_true = z;
      4'b0001: cond_true = ~z;
      4'b0010: cond_true = c;
      4'b0011: cond_true = ~c;
      4'b0100: cond_true = n;
      4'b0101: cond_true = ~n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = ~v;
      4'b1000: cond_true = c & ~z;
      4'b1001: cond_true = ~c | z;
      4'b1010: cond_true = (n == v);
      4'b1011: cond_true = (n != v);
      4'b1100: cond_true = ~z & (n == v);
      4'b1101: cond_true = z | (n != v);
      4'b1110: cond_true = 1'b1;
      4'b1111: cond_true = 1'b0;
    endcase
  end

  // Decode-cycle marker and per-instruction latched condition result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decode_q <= 1'b0;
      cond_q   <= 1'b0;
    end else begin
      decode_q <= IRWrite;
      if (decode_q) cond_q <= cond_true;
    end
  end

  // Decode cycle uses the live evaluation; later cycles use the latched one.
  assign CondEx   = ~reset & (decode_q ? cond_true : cond_q);
  assign PCWrite  = ~reset & (NextPC | (Branch & CondEx));
  assign RegWrite = ~reset & RegW & CondEx;
  assign MemWrite = ~reset & MemW & CondEx;

  // ALU function select and flag-write enables; Funct[5] (I bit) is a don't-care.
  always_comb begin
    alu_op    = ALU_ADD;
    cmd_ok    = 1'b0;
    is_cmp    = 1'b0;
    flag_w_nz = 1'b0;
    flag_w_cv = 1'b0;
    if (ALUOp) begin
      casez (Funct[5:1])
        5'b?0100: begin alu_op = ALU_ADD; cmd_ok = 1'b1; end
        5'b?0010: begin alu_op = ALU_SUB; cmd_ok = 1'b1; end
        5'b?0000: begin alu_op = ALU_AND; cmd_ok = 1'b1; end
        5'b?1100: begin alu_op = ALU_ORR; cmd_ok = 1'b1; end
        5'b?1010: begin alu_op = ALU_SUB; cmd_ok = 1'b1; is_cmp = 1'b1; end
        default:  alu_op = ALU_ADD;
      endcase
      if (is_cmp) begin
        flag_w_nz = 1'b1;
        flag_w_cv = 1'b1;
      end else if (cmd_ok) begin
        flag_w_nz = Funct[0];
        flag_w_cv = Funct[0] & ((alu_op == ALU_ADD) || (alu_op == ALU_SUB));
      end
    end
  end

  assign ALUControl = alu_op;

  // Architectural NZCV register, written only when the instruction executes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= '0;
    end else begin
      if (flag_w_nz & CondEx) Flags[3:2] <= ALUFlags[3:2];
      if (flag_w_cv & CondEx) Flags[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef CONDUNIT_STATS_EN
  // Executed/squashed decode counters, free-running with natural wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExecCnt   <= '0;
      SquashCnt <= '0;
    end else if (decode_q) begin
      if (cond_true) ExecCnt   <= ExecCnt + 16'd1;
      else           SquashCnt <= SquashCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_condunit.sv
// Directed self-checking bench for condunit: condition gating, ALU decode,
// flag register update rules, reset behaviour and (when built with
// CONDUNIT_STATS_EN) the decode counters.
module tb_condunit;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRWrite;
  logic [3:0]  Cond;
  logic [5:0]  Funct;
  logic        ALUOp;
  logic        NextPC;
  logic        RegW;
  logic        MemW;
  logic        Branch;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic [1:0]  ALUControl;
  logic [3:0]  Flags;
  logic        CondEx;
`ifdef CONDUNIT_STATS_EN
  logic [15:0] ExecCnt;
  logic [15:0] SquashCnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Funct encodings {I, cmd[3:0], S}
  localparam logic [5:0] F_SUBS = 6'b000101;
  localparam logic [5:0] F_ADDS = 6'b001001;
  localparam logic [5:0] F_ORRS = 6'b011001;
  localparam logic [5:0] F_ANDS = 6'b000001;
  localparam logic [5:0] F_MOVS = 6'b011011;
  localparam logic [5:0] F_CMP0 = 6'b010100;

  condunit dut (
    .clk        (clk),
    .reset      (reset),
    .IRWrite    (IRWrite),
    .Cond       (Cond),
    .Funct      (Funct),
    .ALUOp      (ALUOp),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW),
    .Branch     (Branch),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .ALUControl (ALUControl),
    .Flags      (Flags),
    .CondEx     (CondEx)
`ifdef CONDUNIT_STATS_EN
    ,
    .ExecCnt    (ExecCnt),
    .SquashCnt  (SquashCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, settle, return for checks.
  task automatic cyc(input logic irw, input logic npc, input logic regw, input logic memw,
                     input logic br, input logic aluop, input logic [3:0] af,
                     input logic [3:0] cond, input logic [5:0] funct);
    @(negedge clk);
    IRWrite  = irw;
    NextPC   = npc;
    RegW     = regw;
    MemW     = memw;
    Branch   = br;
    ALUOp    = aluop;
    ALUFlags = af;
    Cond     = cond;
    Funct    = funct;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset    = 1'b0;
    IRWrite  = 1'b0;
    NextPC   = 1'b0;
    RegW     = 1'b0;
    MemW     = 1'b0;
    Branch   = 1'b0;
    ALUOp    = 1'b0;
    ALUFlags = 4'h0;
    Cond     = 4'h0;
    Funct    = 6'h00;
  endtask

  initial begin
    logic [15:0] cond_tbl;
    logic        found;

    // Reset with every strobe high: all enables must stay low.
    reset = 1'b1; IRWrite = 1'b1; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1; Branch = 1'b1;
    ALUOp = 1'b1; ALUFlags = 4'hF; Cond = 4'hE; Funct = F_SUBS;
    #12;
    check("rst_pcwrite", PCWrite, 1'b0);
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_memwrite", MemWrite, 1'b0);
    check("rst_condex", CondEx, 1'b0);
    check("rst_flags", Flags, 4'h0);
    release_reset();

    // EQ with Z=0: squashed, including the following execute cycle.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 6'h00);
    check("fetch_pcwrite", PCWrite, 1'b1);
    cyc(0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 6'h00);
    check("eq_condex", CondEx, 1'b0);
    check("eq_regwrite", RegWrite, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 6'h00);
    check("eq_hold_regwrite", RegWrite, 1'b0);

    // NE with Z=0: executes.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'h1, 6'h00);
    cyc(0, 0, 1, 0, 0, 0, 4'h0, 4'h1, 6'h00);
    check("ne_condex", CondEx, 1'b1);
    check("ne_regwrite", RegWrite, 1'b1);

    // SUBS AL producing Z, then BEQ taken.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hE, F_SUBS);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_SUBS);
    cyc(0, 0, 0, 0, 0, 1, 4'b0100, 4'hE, F_SUBS);
    check("subs_aluctl", ALUControl, 2'b01);
    check("subs_flags_pre", Flags, 4'h0);
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 6'h00);
    check("subs_flags_post", Flags, 4'b0100);
    cyc(0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 6'h00);
    check("beq_pcwrite", PCWrite, 1'b1);

    // ADDS AL -> Flags=1000; then LT ADDS whose own flag write flips LT.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hE, F_ADDS);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_ADDS);
    cyc(0, 0, 0, 0, 0, 1, 4'b1000, 4'hE, F_ADDS);
    check("adds_aluctl", ALUControl, 2'b00);
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hB, F_ADDS);
    check("flags_1000", Flags, 4'b1000);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hB, F_ADDS);
    check("lt_condex_dec", CondEx, 1'b1);
    cyc(0, 0, 0, 0, 0, 1, 4'b0100, 4'hB, F_ADDS);
    check("lt_condex_exec", CondEx, 1'b1);
    check("lt_flags_pre", Flags, 4'b1000);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hB, F_ADDS);
    check("lt_flags_post", Flags, 4'b0100);
    check("lt_condex_hold", CondEx, 1'b1);

    // Flag write in the same cycle as a decode: condition sees old flags.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'h0, F_SUBS);
    cyc(0, 0, 0, 0, 0, 1, 4'b0000, 4'h0, F_SUBS);
    check("same_condex", CondEx, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, F_SUBS);
    check("same_flags", Flags, 4'b0000);
    check("same_condex_hold", CondEx, 1'b1);

    // ADDS -> 0011, then ORRS updates only N,Z.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hE, F_ADDS);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_ADDS);
    cyc(0, 0, 0, 0, 0, 1, 4'b0011, 4'hE, F_ADDS);
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hE, F_ORRS);
    check("flags_0011", Flags, 4'b0011);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_ORRS);
    cyc(0, 0, 0, 0, 0, 1, 4'b1011, 4'hE, F_ORRS);
    check("orr_aluctl", ALUControl, 2'b11);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_ORRS);
    check("orr_flags", Flags, 4'b1011);

    // ANDS: N,Z only.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hE, F_ANDS);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_ANDS);
    cyc(0, 0, 0, 0, 0, 1, 4'b0100, 4'hE, F_ANDS);
    check("and_aluctl", ALUControl, 2'b10);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_ANDS);
    check("and_flags", Flags, 4'b0111);

    // Unlisted cmd with S=1: add, no flag write.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hE, F_MOVS);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_MOVS);
    cyc(0, 0, 0, 0, 0, 1, 4'b1000, 4'hE, F_MOVS);
    check("other_aluctl", ALUControl, 2'b00);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_MOVS);
    check("other_flags", Flags, 4'b0111);

    // CMP with S=0 still writes all four flags.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hE, F_CMP0);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_CMP0);
    cyc(0, 0, 0, 0, 0, 1, 4'b1010, 4'hE, F_CMP0);
    check("cmp_aluctl", ALUControl, 2'b01);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, F_CMP0);
    check("cmp_flags", Flags, 4'b1010);
    check("aluop0_aluctl", ALUControl, 2'b00);

    // NV: MemWrite squashed, NextPC passes, flag write suppressed.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hF, F_SUBS);
    cyc(0, 1, 0, 1, 0, 0, 4'h0, 4'hF, F_SUBS);
    check("nv_memwrite", MemWrite, 1'b0);
    check("nv_pcwrite", PCWrite, 1'b1);
    check("nv_condex", CondEx, 1'b0);
    cyc(0, 0, 0, 1, 0, 1, 4'b0101, 4'hF, F_SUBS);
    check("nv_exec_memwrite", MemWrite, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hF, F_SUBS);
    check("nv_flags", Flags, 4'b1010);

    // IRWrite held high: every cycle re-decodes. All 16 codes at NZCV=1010.
    cond_tbl = 16'h6996;
    cyc(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 6'h00);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] cc;
      cc = i[3:0];
      cyc(1, 0, 0, 0, 0, 0, 4'h0, cc, 6'h00);
      check($sformatf("cond_%0d", i), CondEx, cond_tbl[i]);
    end
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 6'h00);
    check("burst_last_condex", CondEx, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 6'h00);
    check("burst_hold_condex", CondEx, 1'b1);

    // Reset in the middle of an executing instruction.
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hE, 6'h00);
    cyc(0, 1, 1, 1, 1, 0, 4'h0, 4'hE, 6'h00);
    check("mid_pcwrite", PCWrite, 1'b1);
    check("mid_regwrite", RegWrite, 1'b1);
    check("mid_memwrite", MemWrite, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_pcwrite", PCWrite, 1'b0);
    check("midrst_regwrite", RegWrite, 1'b0);
    check("midrst_memwrite", MemWrite, 1'b0);
    check("midrst_condex", CondEx, 1'b0);
    check("midrst_flags", Flags, 4'h0);
    release_reset();
    cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'h3, 6'h00);
    cyc(0, 0, 1, 0, 0, 0, 4'h0, 4'h3, 6'h00);
    check("postrst_cc_condex", CondEx, 1'b1);
    check("postrst_cc_regwrite", RegWrite, 1'b1);

`ifdef CONDUNIT_STATS_EN
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("stats_rst_exec", ExecCnt, 16'h0000);
    check("stats_rst_squash", SquashCnt, 16'h0000);
    release_reset();
    repeat (3) begin
      cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hE, 6'h00);
      cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, 6'h00);
    end
    repeat (2) begin
      cyc(1, 1, 0, 0, 0, 0, 4'h0, 4'hF, 6'h00);
      cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hF, 6'h00);
    end
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 6'h00);
    check("stats_exec3", ExecCnt, 16'd3);
    check("stats_squash2", SquashCnt, 16'd2);
    found = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      if (ExecCnt == 16'hFFFF) begin
        found = 1'b1;
        break;
      end
      cyc(1, 0, 0, 0, 0, 0, 4'h0, 4'hE, 6'h00);
    end
    check("stats_reach_ffff", found, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, 6'h00);
    check("stats_exec_wrap", ExecCnt, 16'h0000);
    check("stats_squash_keep", SquashCnt, 16'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/condunit.md
# condunit

Conditional-execution and ALU-decode stage sitting directly downstream of the microprogrammed control unit in the multicycle ARM core. It consumes the raw control-word strobes (NextPC, RegW, MemW, Branch, ALUOp) and produces datapath write enables gated by the instruction's condition field. It also produces the ALU function select and owns the architectural NZCV flag register. Each instruction's condition is evaluated once, in its decode cycle, against flags as they stood when that instruction started.

## Interface
Parameters:
- none

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- IRWrite  in  1  instruction register load strobe from control unit; marks the fetch cycle
- Cond  in  4  Instr[31:28] from the instruction register
- Funct  in  6  Instr[25:20]; [4:1] = cmd, [0] = S bit
- ALUOp  in  1  control unit: 0 = plain add, 1 = decode Funct
- NextPC, RegW, MemW, Branch  in  1 each  raw control-unit strobes
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  out  1  NextPC | (Branch & CondEx)
- RegWrite  out  1  RegW & CondEx
- MemWrite  out  1  MemW & CondEx
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr
- Flags  out  4  registered {N,Z,C,V}
- CondEx  out  1  effective condition result for the current instruction

## Operation
- decode_q: register, loads IRWrite every cycle; high exactly in the decode cycle.
- condtrue(Cond, Flags), evaluated on the registered Flags:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0
- cond_q: register; on an edge with decode_q=1 it loads condtrue; otherwise it holds.
- CondEx = decode_q ? condtrue : cond_q.
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, by cmd: 0100 add; 0010 sub; 0000 and; 1100 orr; 1010 (CMP) sub.
  - Any other cmd: add, FlagW=00.
  - FlagW[1] = S. FlagW[0] = S & ALUControl∈{00,01}. CMP forces FlagW=11.
- Flag write: on an edge, {N,Z} <= ALUFlags[3:2] if FlagW[1]&CondEx; {C,V} <= ALUFlags[1:0] if FlagW[0]&CondEx.

## Timing
- Reset values: Flags=0000, cond_q=0, decode_q=0. While reset is high, PCWrite/RegWrite/MemWrite=0 and CondEx=0 regardless of inputs.
- PCWrite/RegWrite/MemWrite/ALUControl/CondEx: combinational, zero latency from inputs.
- Flags visible the cycle after the write edge.
- Same-cycle flag write and decode: condtrue uses pre-update Flags.
- Fetch-cycle NextPC is never gated by the condition.
- Reset mid-instruction: all state clears. The first decode after reset evaluates against Flags=0000.
- IRWrite held high on consecutive cycles: each following cycle is a decode cycle and re-evaluates the condition.

## Configuration
- CONDUNIT_STATS_EN defined:
  - adds outputs ExecCnt[15:0] and SquashCnt[15:0], both reset to 0.
  - On each decode_q=1 edge, ExecCnt increments if condtrue=1, else SquashCnt increments.
  - Both wrap 0xFFFF -> 0x0000.
- CONDUNIT_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, Flags=0000, Cond=0000 (EQ) decoded, RegW=1 -> CondEx=0, RegWrite=0; Cond=0001 (NE) -> RegWrite=1.
- SUBS producing ALUFlags=0100 (Z) with cond AL -> Flags=0100 the next cycle; following BEQ with Branch=1 -> PCWrite=1.
- Flags=1000, Cond=1011 (LT), ADDS with ALUFlags=0100 in the same instruction -> CondEx stays 1 through the instruction; Flags become 0100 only after the write edge.
- ORRS (cmd 1100, S=1), ALUFlags=1011 -> ALUControl=11, only N,Z updated: Flags goes from 0011 to 1011's {N,Z}=10, giving 1011.
- Cond=1111 with MemW=1, NextPC=1 -> MemWrite=0, PCWrite=1. Assert reset mid-instruction -> all write enables 0, Flags=0000.
- With CONDUNIT_STATS_EN: 3 executed + 2 squashed decodes -> ExecCnt=3, SquashCnt=2. Preload to 0xFFFF, one more -> 0x0000.
